// File: rtl/fsm_pkg.sv
// Shared definitions for the two-way traffic light controller.
// Holds the state enumeration, the light codes and small helpers
// used by the controller top and its phase timer.
package fsm_pkg;

    // Light codes driven on the controller's light output
    localparam logic [1:0] LIGHT_RED = 2'b00;
    localparam logic [1:0] LIGHT_N   = 2'b01;
    localparam logic [1:0] LIGHT_W   = 2'b10;
    localparam logic [1:0] LIGHT_Y   = 2'b11;

    // Controller states; the 3-bit encoding leaves three unused codes
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        N_GREEN  = 3'd1,
        N_YELLOW = 3'd2,
        W_GREEN  = 3'd3,
        W_YELLOW = 3'd4
    } state_t;

    // Larger of two phase lengths; sizes the shared countdown
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Moore decode of the light code from a state; unused codes show red
    function automatic logic [1:0] light_of(input state_t s);
        logic [1:0] code;
        code = LIGHT_RED;
        case (s)
            N_GREEN:  code = LIGHT_N;
            W_GREEN:  code = LIGHT_W;
            N_YELLOW: code = LIGHT_Y;
            W_YELLOW: code = LIGHT_Y;
            default:  code = LIGHT_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/fsm_phase_timer.sv
// Phase countdown for the traffic light controller.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset, clears the count to 0
//   load     - load strobe, asserted on the edge that enters a new state
//   load_val - remaining cycles after the entry cycle (phase length - 1)
//   done_c   - combinational, high while the count sits at zero
module phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] cnt;

    // Load on state entry, otherwise count down and hold at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done_c = (cnt == '0);

endmodule

// File: rtl/fsm.sv
// Two-way (north/west) traffic light controller.
// A request sampled in IDLE starts a green phase of GREEN_CYCLES cycles,
// followed by a yellow phase of YELLOW_CYCLES cycles, then back to IDLE.
// North wins over west when both are sampled together; requests seen
// outside IDLE are ignored and never queued.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   n     - north request, sampled on the rising edge
//   w     - west request, sampled on the rising edge
//   light - registered light code: 00 red, 01 north, 10 west, 11 yellow
module fsm
    import fsm_pkg::*;
#(
    parameter int unsigned GREEN_CYCLES  = 2,
    parameter int unsigned YELLOW_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       n,
    input  logic       w,
    output logic [1:0] light
);

    localparam int unsigned CNT_W = $clog2(max_u(GREEN_CYCLES, YELLOW_CYCLES) + 1);

    // Entry cycle is counted by the load edge itself, hence the -1
    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic               load_c;
    logic [CNT_W-1:0]   load_val_c;
    logic               done_c;

    // Next-state logic; the timer is reloaded on every state change
    always_comb begin
        state_nxt  = state;
        load_c     = 1'b0;
        load_val_c = '0;
        case (state)
            IDLE: begin
                if (n) begin
                    state_nxt  = N_GREEN;
                    load_c     = 1'b1;
                    load_val_c = GREEN_LOAD;
                end else if (w) begin
                    state_nxt  = W_GREEN;
                    load_c     = 1'b1;
                    load_val_c = GREEN_LOAD;
                end
            end
            N_GREEN: begin
                if (done_c) begin
                    state_nxt  = N_YELLOW;
                    load_c     = 1'b1;
                    load_val_c = YELLOW_LOAD;
                end
            end
            W_GREEN: begin
                if (done_c) begin
                    state_nxt  = W_YELLOW;
                    load_c     = 1'b1;
                    load_val_c = YELLOW_LOAD;
                end
            end
            N_YELLOW, W_YELLOW: begin
                if (done_c) begin
                    state_nxt = IDLE;
                    load_c    = 1'b1;
                end
            end
            default: begin
                // Unused encodings fall back to IDLE with a cleared timer
                state_nxt = IDLE;
                load_c    = 1'b1;
            end
        endcase
    end

    // State register; light is decoded from the next state so it tracks
    // the registered state with no extra cycle of lag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            light <= LIGHT_RED;
        end else begin
            state <= state_nxt;
            light <= light_of(state_nxt);
        end
    end

    phase_timer #(
        .W(CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_c),
        .load_val (load_val_c),
        .done_c   (done_c)
    );

endmodule

// File: tb/tb_fsm.sv
// Self-checking bench for the traffic light controller.
// Two instances (default timing and GREEN=3/YELLOW=2) are driven with the
// same directed and random request streams and compared every cycle
// against a remaining-cycles reference model.
module tb_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       n;
    logic       w;
    logic [1:0] light_a;
    logic [1:0] light_b;

    fsm dut_a (
        .clk   (clk),
        .reset (reset),
        .n     (n),
        .w     (w),
        .light (light_a)
    );

    fsm #(
        .GREEN_CYCLES  (3),
        .YELLOW_CYCLES (2)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .n     (n),
        .w     (w),
        .light (light_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles left in the current service and its colour
    int         gc [2] = '{2, 3};
    int         yc [2] = '{1, 2};
    int         rem [2] = '{0, 0};
    logic [1:0] dirc [2] = '{2'b00, 2'b00};

    function automatic logic [1:0] exp_light(input int i);
        if (rem[i] == 0)      return 2'b00;
        else if (rem[i] > yc[i]) return dirc[i];
        else                  return 2'b11;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                rem[i] = 0;
            end else if (rem[i] == 0) begin
                if (n) begin
                    dirc[i] = 2'b01;
                    rem[i]  = gc[i] + yc[i];
                end else if (w) begin
                    dirc[i] = 2'b10;
                    rem[i]  = gc[i] + yc[i];
                end
            end else begin
                rem[i] = rem[i] - 1;
            end
        end
    endtask

    task automatic check(input logic [1:0] obs, input logic [1:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag);
        check(light_a, exp_light(0), {tag, "_a"});
        check(light_b, exp_light(1), {tag, "_b"});
    endtask

    task automatic step(input logic nn, input logic ww, input string tag);
        n = nn;
        w = ww;
        @(posedge clk);
        model_edge();
        #1;
        check_both(tag);
    endtask

    initial begin
        reset = 1'b0;
        n     = 1'b0;
        w     = 1'b0;
        #1;
        check_both("rst_async");
        @(posedge clk);
        model_edge();
        #1;
        check_both("rst_hold");
        reset = 1'b1;
        repeat (3) step(1'b0, 1'b0, "idle_after_rst");

        // Single north pulse
        step(1'b1, 1'b0, "npulse");
        repeat (6) step(1'b0, 1'b0, "npulse_tail");

        // North then west on the next cycle: west is dropped
        step(1'b1, 1'b0, "n_then_w");
        step(1'b0, 1'b1, "n_then_w_w");
        repeat (6) step(1'b0, 1'b0, "n_then_w_tail");

        // West then north on the next cycle: north is dropped
        step(1'b0, 1'b1, "w_then_n");
        step(1'b1, 1'b0, "w_then_n_n");
        repeat (6) step(1'b0, 1'b0, "w_then_n_tail");

        // Simultaneous request: north wins
        step(1'b1, 1'b1, "both");
        repeat (6) step(1'b0, 1'b0, "both_tail");

        // Held requests are re-served with an IDLE gap in between
        repeat (12) step(1'b1, 1'b0, "held_n");
        repeat (12) step(1'b0, 1'b1, "held_w");
        repeat (6) step(1'b0, 1'b0, "held_tail");

        // Reset during the second north green cycle
        step(1'b1, 1'b0, "rst_mid_go");
        step(1'b0, 1'b0, "rst_mid_g2");
        #2;
        reset = 1'b0;
        #1;
        check(light_a, 2'b00, "rst_mid_async_a");
        check(light_b, 2'b00, "rst_mid_async_b");
        rem[0] = 0;
        rem[1] = 0;
        step(1'b0, 1'b0, "rst_mid_low");
        reset = 1'b1;
        step(1'b0, 1'b0, "rst_mid_rel");
        step(1'b0, 1'b1, "after_rel");
        repeat (7) step(1'b0, 1'b0, "after_rel_tail");

        // Random requests with occasional resets
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 59) != 0);
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), "random");
        end
        reset = 1'b1;
        repeat (8) step(1'b0, 1'b0, "final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
